// File: rtl/sobel_window_feeder.sv
// Horizontal 3-pixel window generator for a Sobel stage.
// Accepts a raster pixel stream and emits one window per pixel. Row edges are
// handled by replicating the edge pixel. The last window of each row is
// produced from a FLUSH state that blocks input for exactly one cycle.
module sobel_window_feeder #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_in,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       in_ready,
    output logic [7:0] left_out,
    output logic [7:0] current_out,
    output logic [7:0] right_out,
    output logic       out_valid,
    output logic [9:0] out_col,
    output logic [9:0] out_row,
    output logic       out_eof
);

    localparam logic [9:0] LAST_COL = 10'(WIDTH - 1);
    localparam logic [9:0] LAST_ROW = 10'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ROW_START = 2'd0,
        RUN       = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;

    // Column index of the next pixel to be accepted, and the current row.
    logic [9:0] col;
    logic [9:0] row;

    // prev1 holds p[c-1], prev2 holds p[c-2] relative to the next pixel.
    logic [7:0] prev1;
    logic [7:0] prev2;

    // Datapath controls decoded from the FSM.
    logic       start_row;   // accepted pixel becomes column 0
    logic       new_frame;   // accepted pixel carries in_sof
    logic       emit_run;    // accepted pixel completes a window
    logic       emit_flush;  // emit the replicated right-edge window

    // Next-state, handshake and datapath control decode.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        start_row  = 1'b0;
        new_frame  = 1'b0;
        emit_run   = 1'b0;
        emit_flush = 1'b0;
        case (state)
            ROW_START: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    start_row  = 1'b1;
                    new_frame  = in_sof;
                    next_state = RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_sof) begin
                        // A new frame start abandons the partial row.
                        start_row  = 1'b1;
                        new_frame  = 1'b1;
                        next_state = RUN;
                    end else begin
                        emit_run = 1'b1;
                        if (col == LAST_COL) begin
                            next_state = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                // Input is blocked; the last window needs no new pixel.
                emit_flush = 1'b1;
                next_state = ROW_START;
            end
            default: begin
                next_state = ROW_START;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ROW_START;
        end else begin
            state <= next_state;
        end
    end

    // Pixel history and column/row counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev1 <= 8'd0;
            prev2 <= 8'd0;
            col   <= 10'd0;
            row   <= 10'd0;
        end else begin
            if (start_row) begin
                // Column 0 is loaded into both taps so column 1 sees p[0]
                // on its left (left-edge replication).
                prev1 <= pixel_in;
                prev2 <= pixel_in;
                col   <= 10'd1;
                if (new_frame) begin
                    row <= 10'd0;
                end
            end else if (emit_run) begin
                prev2 <= prev1;
                prev1 <= pixel_in;
                col   <= col + 10'd1;
            end else if (emit_flush) begin
                col <= 10'd0;
                row <= (row == LAST_ROW) ? 10'd0 : row + 10'd1;
            end
        end
    end

    // Registered window outputs; valid/eof are single-cycle pulses while
    // window data and coordinates hold between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_out    <= 8'd0;
            current_out <= 8'd0;
            right_out   <= 8'd0;
            out_valid   <= 1'b0;
            out_col     <= 10'd0;
            out_row     <= 10'd0;
            out_eof     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            if (emit_run) begin
                left_out    <= prev2;
                current_out <= prev1;
                right_out   <= pixel_in;
                out_col     <= col - 10'd1;
                out_row     <= row;
                out_valid   <= 1'b1;
            end else if (emit_flush) begin
                // Right-edge replication: the last pixel is its own right.
                left_out    <= prev2;
                current_out <= prev1;
                right_out   <= prev1;
                out_col     <= LAST_COL;
                out_row     <= row;
                out_valid   <= 1'b1;
                out_eof     <= (row == LAST_ROW);
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Scoreboard bench for sobel_window_feeder: a 4x2 instance for streaming,
// stall, row/eof, reset and sof cases, and a 2x1 instance for the narrowest row.
module tb_sobel_window_feeder;

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] c;
        logic [7:0] r;
        logic [9:0] col;
        logic [9:0] row;
        logic       eof;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: WIDTH=4, HEIGHT=2
    logic [7:0] a_pixel = '0;
    logic       a_valid = 1'b0;
    logic       a_sof   = 1'b0;
    logic       a_ready;
    logic [7:0] a_left, a_cur, a_right;
    logic       a_ovalid, a_eof;
    logic [9:0] a_col, a_row;

    // Instance B: WIDTH=2, HEIGHT=1
    logic [7:0] b_pixel = '0;
    logic       b_valid = 1'b0;
    logic       b_sof   = 1'b0;
    logic       b_ready;
    logic [7:0] b_left, b_cur, b_right;
    logic       b_ovalid, b_eof;
    logic [9:0] b_col, b_row;

    sobel_window_feeder #(.WIDTH(4), .HEIGHT(2)) dut_a (
        .clk(clk), .rst(rst), .pixel_in(a_pixel), .in_valid(a_valid), .in_sof(a_sof),
        .in_ready(a_ready), .left_out(a_left), .current_out(a_cur), .right_out(a_right),
        .out_valid(a_ovalid), .out_col(a_col), .out_row(a_row), .out_eof(a_eof)
    );

    sobel_window_feeder #(.WIDTH(2), .HEIGHT(1)) dut_b (
        .clk(clk), .rst(rst), .pixel_in(b_pixel), .in_valid(b_valid), .in_sof(b_sof),
        .in_ready(b_ready), .left_out(b_left), .current_out(b_cur), .right_out(b_right),
        .out_valid(b_ovalid), .out_col(b_col), .out_row(b_row), .out_eof(b_eof)
    );

    int   errors = 0;
    int   checks = 0;
    win_t qa[$];
    win_t qb[$];
    win_t ea, eb, ga, gb;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic win_t mk(input int l, input int c, input int r,
                                input int col, input int row, input int eof);
        win_t w;
        w.l = 8'(l); w.c = 8'(c); w.r = 8'(r);
        w.col = 10'(col); w.row = 10'(row); w.eof = 1'(eof);
        return w;
    endfunction

    // Present a pixel on A until accepted (bounded), return on the next negedge.
    task automatic send_a(input int p, input logic sof);
        a_pixel = 8'(p);
        a_sof   = sof;
        a_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (a_ready) begin
                @(negedge clk);
                a_valid = 1'b0;
                a_sof   = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL send_a_timeout: pixel %0d never accepted", p);
        a_valid = 1'b0;
        a_sof   = 1'b0;
    endtask

    task automatic send_b(input int p, input logic sof);
        b_pixel = 8'(p);
        b_sof   = sof;
        b_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (b_ready) begin
                @(negedge clk);
                b_valid = 1'b0;
                b_sof   = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL send_b_timeout: pixel %0d never accepted", p);
        b_valid = 1'b0;
        b_sof   = 1'b0;
    endtask

    // Monitor A: every out_valid pops one expected window.
    always @(negedge clk) begin
        if (a_ovalid === 1'b1) begin
            checks++;
            ga = {a_left, a_cur, a_right, a_col, a_row, a_eof};
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected: window %0d,%0d,%0d col %0d row %0d eof %0d, required none",
                         a_left, a_cur, a_right, a_col, a_row, a_eof);
            end else begin
                ea = qa.pop_front();
                if (ga !== ea) begin
                    errors++;
                    $display("FAIL a_window: got %0d,%0d,%0d col %0d row %0d eof %0d required %0d,%0d,%0d col %0d row %0d eof %0d",
                             ga.l, ga.c, ga.r, ga.col, ga.row, ga.eof,
                             ea.l, ea.c, ea.r, ea.col, ea.row, ea.eof);
                end
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (b_ovalid === 1'b1) begin
            checks++;
            gb = {b_left, b_cur, b_right, b_col, b_row, b_eof};
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: window %0d,%0d,%0d col %0d row %0d eof %0d, required none",
                         b_left, b_cur, b_right, b_col, b_row, b_eof);
            end else begin
                eb = qb.pop_front();
                if (gb !== eb) begin
                    errors++;
                    $display("FAIL b_window: got %0d,%0d,%0d col %0d row %0d eof %0d required %0d,%0d,%0d col %0d row %0d eof %0d",
                             gb.l, gb.c, gb.r, gb.col, gb.row, gb.eof,
                             eb.l, eb.c, eb.r, eb.col, eb.row, eb.eof);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 32'(a_ovalid), 0);
        chk("rst_out_eof", 32'(a_eof), 0);
        chk("rst_window", {8'd0, a_left, a_cur, a_right}, 0);
        chk("rst_out_col", 32'(a_col), 0);
        chk("rst_out_row", 32'(a_row), 0);
        chk("rst_in_ready", 32'(a_ready), 1);

        // Row 0 streamed continuously
        send_a(10, 1'b1);
        qa.push_back(mk(10, 10, 20, 0, 0, 0)); send_a(20, 1'b0);
        qa.push_back(mk(10, 20, 30, 1, 0, 0)); send_a(30, 1'b0);
        qa.push_back(mk(20, 30, 40, 2, 0, 0));
        qa.push_back(mk(30, 40, 40, 3, 0, 0)); send_a(40, 1'b0);
        chk("flush_in_ready_low", 32'(a_ready), 0);
        @(negedge clk);
        chk("post_flush_in_ready_high", 32'(a_ready), 1);

        // Row 1 with a 3-cycle stall between 20 and 30; last window of frame
        send_a(10, 1'b0);
        qa.push_back(mk(10, 10, 20, 0, 1, 0)); send_a(20, 1'b0);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            chk("gap_out_valid", 32'(a_ovalid), 0);
        end
        qa.push_back(mk(10, 20, 30, 1, 1, 0)); send_a(30, 1'b0);
        qa.push_back(mk(20, 30, 40, 2, 1, 0));
        qa.push_back(mk(30, 40, 40, 3, 1, 1)); send_a(40, 1'b0);

        // Row counter wraps back to 0
        send_a(1, 1'b0);
        qa.push_back(mk(1, 1, 2, 0, 0, 0)); send_a(2, 1'b0);
        qa.push_back(mk(1, 2, 3, 1, 0, 0)); send_a(3, 1'b0);
        qa.push_back(mk(2, 3, 4, 2, 0, 0));
        qa.push_back(mk(3, 4, 4, 3, 0, 0)); send_a(4, 1'b0);

        // Reset mid-row (row 1) with a simultaneous valid pixel
        send_a(10, 1'b0);
        qa.push_back(mk(10, 10, 20, 0, 1, 0)); send_a(20, 1'b0);
        a_pixel = 8'd30;
        a_valid = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        a_valid = 1'b0;
        chk("midrst_out_valid", 32'(a_ovalid), 0);
        chk("midrst_current", 32'(a_cur), 0);
        chk("midrst_out_col", 32'(a_col), 0);
        chk("midrst_in_ready", 32'(a_ready), 1);
        send_a(50, 1'b0);
        qa.push_back(mk(50, 50, 60, 0, 0, 0)); send_a(60, 1'b0);
        qa.push_back(mk(50, 60, 70, 1, 0, 0)); send_a(70, 1'b0);
        qa.push_back(mk(60, 70, 80, 2, 0, 0));
        qa.push_back(mk(70, 80, 80, 3, 0, 0)); send_a(80, 1'b0);

        // Row 1 partial, then sof mid-row restarts at col 0, row 0
        send_a(5, 1'b0);
        qa.push_back(mk(5, 5, 6, 0, 1, 0)); send_a(6, 1'b0);
        send_a(99, 1'b1);
        chk("sof_no_output", 32'(a_ovalid), 0);
        qa.push_back(mk(99, 99, 100, 0, 0, 0)); send_a(100, 1'b0);
        qa.push_back(mk(99, 100, 101, 1, 0, 0)); send_a(101, 1'b0);
        qa.push_back(mk(100, 101, 102, 2, 0, 0));
        qa.push_back(mk(101, 102, 102, 3, 0, 0)); send_a(102, 1'b0);

        // WIDTH=2, HEIGHT=1: single-row frame, both windows edge-replicated
        send_b(5, 1'b1);
        qb.push_back(mk(5, 5, 7, 0, 0, 0));
        qb.push_back(mk(5, 7, 7, 1, 0, 1)); send_b(7, 1'b0);

        repeat (4) @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 0);
        chk("b_queue_drained", 32'(qb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
